// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed multiply/divide unit owning HI/LO
//
// Executes the mult, div, mfhi and mflo commands from the instruction decoder.
// Multiply is radix-2 shift-add and divide is restoring, one step per cycle on
// operand magnitudes. A final FIX cycle applies the signs and writes HI/LO.
//
// Optional feature macro: MULDIV_FAST_MULT_EN
//   defined   : mult writes {HI,LO} from a single-cycle signed multiply on the
//               start edge; busy never asserts for mult.
//   undefined : iterative multiply taking WIDTH+1 busy cycles.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   mult      in   1      start a signed multiply (taken only while idle)
//   div       in   1      start a signed divide (mult wins if both are set)
//   mfhi      in   1      select HI onto hilo_out
//   mflo      in   1      select LO onto hilo_out
//   srca      in   WIDTH  rs operand (multiplicand / dividend)
//   srcb      in   WIDTH  rt operand (multiplier / divisor)
//   busy      out  1      operation in flight (registered)
//   stall     out  1      freeze PC / regfile write this cycle
//   hilo_out  out  WIDTH  mfhi ? HI : LO

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult,
    input  logic             div,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   busy_q;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      cnt;
    // Magnitude of the multiplicand (MUL) or divisor (DIV).
    logic [WIDTH:0]     opnd;
    // MUL: {partial product upper, multiplier shifting out}.
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH+1:0] acc;
    logic               neg_ab;
    logic               neg_a;
    logic               op_div;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   mag_a;
    logic [WIDTH:0]   mag_b;
    logic             start_mul;
    logic             start_div;
    logic             div_zero;

    // Sign-extend to WIDTH+1 before negating so -2^(WIDTH-1) stays exact.
    assign a_neg     = srca[WIDTH-1];
    assign b_neg     = srcb[WIDTH-1];
    assign mag_a     = a_neg ? -{srca[WIDTH-1], srca} : {1'b0, srca};
    assign mag_b     = b_neg ? -{srcb[WIDTH-1], srcb} : {1'b0, srcb};
    assign start_mul = mult;
    assign start_div = div & ~mult;
    assign div_zero  = start_div & (srcb == '0);

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] prod_fast;
    assign prod_fast = $signed({{WIDTH{srca[WIDTH-1]}}, srca}) *
                       $signed({{WIDTH{srcb[WIDTH-1]}}, srcb});
`endif

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    logic [WIDTH+1:0]   mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ge;
    logic [2*WIDTH+1:0] acc_step;

    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the whole accumulator right by one.
    assign mul_sum   = acc[2*WIDTH+1:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);

    // Restoring divide: bring the next dividend bit into the remainder and
    // keep the trial difference only when it does not borrow.
    assign div_shift = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};
    assign div_ge    = (div_shift >= {1'b0, opnd});

    always_comb begin
        acc_step = acc;
        if (state == S_MUL) begin
            acc_step = {mul_sum, acc[WIDTH-1:0]} >> 1;
        end else if (state == S_DIV) begin
            acc_step = {(div_ge ? div_trial : div_shift), acc[WIDTH-2:0], div_ge};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up of the final result
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_mag    = acc[2*WIDTH-1:0];
    assign prod_signed = neg_ab ? -prod_mag : prod_mag;
    assign quo_mag     = acc[WIDTH-1:0];
    assign rem_mag     = acc[2*WIDTH-1:WIDTH];
    // -2^(W-1) / -1 yields quotient magnitude 2^(W-1), which wraps naturally.
    assign fix_lo = op_div ? (neg_ab ? -quo_mag : quo_mag) : prod_signed[WIDTH-1:0];
    assign fix_hi = op_div ? (neg_a  ? -rem_mag : rem_mag) : prod_signed[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_mul) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_next = S_IDLE;
`else
                    state_next = S_MUL;
`endif
                end else if (start_div && !div_zero) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == '0) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = busy_q;
        stall    = busy_q & (mult | div | mfhi | mflo);
        hilo_out = mfhi ? hi : lo;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg_ab <= 1'b0;
            neg_a  <= 1'b0;
            op_div <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_mul) begin
`ifdef MULDIV_FAST_MULT_EN
                        hi <= prod_fast[2*WIDTH-1:WIDTH];
                        lo <= prod_fast[WIDTH-1:0];
`else
                        acc    <= {{(WIDTH+2){1'b0}}, mag_b[WIDTH-1:0]};
                        opnd   <= mag_a;
                        cnt    <= CNT_LAST;
                        neg_ab <= a_neg ^ b_neg;
                        neg_a  <= a_neg;
                        op_div <= 1'b0;
`endif
                    end else if (start_div) begin
                        if (div_zero) begin
                            hi <= srca;
                            lo <= '1;
                        end else begin
                            acc    <= {{(WIDTH+2){1'b0}}, mag_a[WIDTH-1:0]};
                            opnd   <= mag_b;
                            cnt    <= CNT_LAST;
                            neg_ab <= a_neg ^ b_neg;
                            neg_a  <= a_neg;
                            op_div <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule
